// File: rtl/dsram_responder.sv
// dsram_responder: single-port data SRAM model with a CPU-style req/addr_ok/data_ok
// handshake. Writes commit on the accept edge, and reads sample memory on that
// same edge. Each response waits in an in-order queue until its latency timer
// has expired.
// Optional feature: define DSRAM_ALIGN_CHECK_EN to flag misaligned requests
// and requests with a size/wstrb mismatch. A flagged request is accepted, commits
// no write, and answers with err=1 and rdata=0.
module dsram_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   mem [0:(1 << AW) - 1];
    logic [31:0]   q_word [QDEPTH];
    logic          q_wr [QDEPTH];
    logic          q_err [QDEPTH];
    logic [2:0]    q_timer [QDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          pop;
    logic          bad;
    logic [3:0]    commit_strb;
    logic [AW-1:0] widx;

    assign widx    = addr[AW+1:2];
    // A full queue refuses new work, even in a cycle where the head pops.
    assign addr_ok = resetn & req & (count < CW'(QDEPTH));
    assign accept  = addr_ok;
    assign data_ok = (count != '0) && (q_timer[rptr] == 3'd0);
    assign pop     = data_ok;
    assign rdata   = (data_ok && !q_wr[rptr] && !q_err[rptr]) ? q_word[rptr] : 32'h0;

`ifdef DSRAM_ALIGN_CHECK_EN
    logic [3:0] size_mask;
    logic       unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    // Classify the request: misaligned, illegal size, or strobes that do not match size/offset.
    always_comb begin
        size_mask = 4'b0000;
        case (size)
            2'd0:    size_mask = 4'b0001 << addr[1:0];
            2'd1:    size_mask = 4'b0011 << addr[1:0];
            2'd2:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        bad = ((size == 2'd1) && addr[0])
           || ((size == 2'd2) && (addr[1:0] != 2'b00))
           || (size == 2'd3)
           || (wr && (wstrb != size_mask));
        commit_strb = bad ? 4'b0000 : wstrb;
    end

    assign err = data_ok & q_err[rptr];
`else
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0], size};
    assign bad         = 1'b0;
    assign commit_strb = wstrb;
    assign err         = 1'b0;
`endif

    // Commit the enabled bytes of a write, and capture the addressed word for the new entry.
    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (wr && commit_strb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            q_word[wptr] <= mem[widx];
        end
    end

    // Queue pointers and occupancy. Both pointers wrap at QDEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                wptr <= (wptr == PW'(QDEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(QDEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
            // Load the entry when a request is pushed; otherwise count its timer down to zero.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    q_wr[gi]    <= 1'b0;
                    q_err[gi]   <= 1'b0;
                    q_timer[gi] <= 3'd0;
                end else if (accept && (wptr == PW'(gi))) begin
                    q_wr[gi]    <= wr;
                    q_err[gi]   <= bad;
                    q_timer[gi] <= 3'(LATENCY - 1);
                end else if (q_timer[gi] != 3'd0) begin
                    q_timer[gi] <= q_timer[gi] - 3'd1;
                end
            end
        end
    endgenerate

endmodule

// File: doc/dsram_responder.md
DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 Parameter AW, default 10, SHALL set the word-address width; memory depth is 2**AW 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..7, SHALL set the number of cycles from request acceptance to data_ok.
REQ-003 Parameter QDEPTH, default 2, SHALL set the maximum number of outstanding accepted requests.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  request valid from the CPU data port.
REQ-007 wr  input  1  1 = write, 0 = read.
REQ-008 size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-009 addr  input  32  byte address; addr[AW+1:2] selects the word.
REQ-010 wdata  input  32  write data, lane-aligned.
REQ-011 wstrb  input  4  write byte enables; bit i enables wdata[8i+7:8i].
REQ-012 addr_ok  output  1  request accepted this cycle.
REQ-013 data_ok  output  1  one-cycle response pulse.
REQ-014 rdata  output  32  full read word, valid while data_ok is high.
REQ-015 err  output  1  response error, valid while data_ok is high.

Function
REQ-016 addr_ok SHALL equal req AND (outstanding count < QDEPTH), combinationally; there is no full-queue bypass.
REQ-017 Accept SHALL occur on any edge where req and addr_ok are both high; at most one accept per cycle.
REQ-018 On an accepted write, enabled bytes SHALL be committed to memory on the accept edge; disabled bytes SHALL be left unchanged.
REQ-019 On an accepted read, the addressed word SHALL be sampled on the accept edge into the queue entry; a read therefore returns data from all earlier-accepted writes.
REQ-020 Each accepted request SHALL occupy one in-order FIFO entry holding its read word, wr flag, err flag and a timer loaded with LATENCY-1.
REQ-021 Timers of all valid entries SHALL decrement each cycle, saturating at 0.
REQ-022 data_ok SHALL be high in a cycle iff the queue is non-empty and the head timer is 0; the head SHALL pop on that edge.
REQ-023 Response cycle for each request = max(accept cycle + LATENCY, previous response cycle + 1); responses SHALL be strictly in acceptance order.
REQ-024 rdata SHALL be the sampled word for read responses and 0 for write responses, and 0 whenever data_ok is low.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo QDEPTH.
REQ-026 When the queue is full, addr_ok SHALL be low even if a pop occurs in the same cycle.
REQ-027 Lane extraction and sign extension SHALL NOT be performed here; they are the requester's job.

Reset
REQ-028 While resetn is low: addr_ok = 0, data_ok = 0, rdata = 0, err = 0, queue empty, pointers and count = 0.
REQ-029 Reset asserted mid-operation SHALL drop all outstanding responses; writes already committed SHALL persist.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro DSRAM_ALIGN_CHECK_EN defined: a request is flagged bad when
  - size=1 and addr[0]=1, or
  - size=2 and addr[1:0]≠0, or
  - size=3, or
  - it is a write whose wstrb differs from the mask implied by size and addr[1:0] (byte 0001<<a, half 0011<<a, word 1111).
  A bad request SHALL be accepted and SHALL commit no write; its response SHALL carry err=1 and rdata=0.
REQ-032 Macro undefined: err SHALL be constant 0, and writes SHALL use wstrb as given with no checks.

Verification
REQ-033 LATENCY=2: write addr 0x10, wdata 0xAABBCCDD, wstrb 1111 accepted at cycle 5 -> data_ok at cycle 7 with rdata 0. Then read 0x10 -> rdata 0xAABBCCDD.
REQ-034 Word 0x20 = 0x11223344; write wdata 0x00EE0000, wstrb 0100 -> subsequent read returns 0x11EE3344.
REQ-035 QDEPTH=2, LATENCY=3, req held high from cycle 0 -> addr_ok at cycles 0 and 1, low at cycle 2, high again at cycle 4 (after the pop at cycle 3); data_ok at cycles 3, 4, 7.
REQ-036 Two reads accepted back-to-back -> two consecutive data_ok pulses in order. Write accepted one cycle before a read of the same address -> the read returns the written data.
REQ-037 resetn pulsed low with 2 requests outstanding -> no data_ok after release, addr_ok high on the next request, earlier committed writes readable.
REQ-038 With DSRAM_ALIGN_CHECK_EN: write size=2, addr 0x22 -> err=1 with data_ok, memory unchanged. Without the macro: the same request writes with err=0.
